// File: rtl/song_note_reader_pkg.sv
// Shared types for the multi-song note reader: field widths, entry layout,
// reader states, terminator test and the compiled-in song image.
package song_pkg;

  localparam int DEF_SONGS = 4;
  localparam int DEF_NOTES = 32;
  localparam int DEF_SONG_W = $clog2(DEF_SONGS);
  localparam int DEF_IDX_W = $clog2(DEF_NOTES);
  localparam int ROM_AW = DEF_SONG_W + DEF_IDX_W;

  localparam int F_NOTE_W = 6;
  localparam int F_DUR_W = 6;
  localparam int F_META_W = 3;
  localparam int ENTRY_W = 1 + F_NOTE_W + F_DUR_W + F_META_W;

  typedef struct packed {
    logic                adv;
    logic [F_NOTE_W-1:0] note;
    logic [F_DUR_W-1:0]  dur;
    logic [F_META_W-1:0] meta;
  } note_entry_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_PRESENT,
    S_DONE
  } rd_state_t;

  function automatic logic is_terminator(note_entry_t e);
    return (e.dur == '0);
  endfunction

  function automatic note_entry_t mk(
    logic                adv,
    logic [F_NOTE_W-1:0] note,
    logic [F_DUR_W-1:0]  dur,
    logic [F_META_W-1:0] meta
  );
    note_entry_t e;
    e.adv = adv;
    e.note = note;
    e.dur = dur;
    e.meta = meta;
    return e;
  endfunction

  // Song-major image: song 0 fills all slots, songs 1-3 end on dur==0.
  function automatic note_entry_t song_image(logic [ROM_AW-1:0] a);
    logic [DEF_SONG_W-1:0] s;
    logic [DEF_IDX_W-1:0]  i;
    note_entry_t           e;
    s = a[ROM_AW-1:DEF_IDX_W];
    i = a[DEF_IDX_W-1:0];
    e = '0;
    case (s)
      2'd0: e = mk(i[0], {1'b0, i} + 6'd1,
                   {1'b0, i} + 6'd1, i[2:0]);
      2'd1: begin
        if (i == 5'd0) e = mk(1'b1, 6'd44, 6'd8, 3'd1);
        if (i == 5'd1) e = mk(1'b1, 6'd47, 6'd8, 3'd2);
      end
      2'd2: begin
        if (i == 5'd0) e = mk(1'b0, 6'd50, 6'd4, 3'd3);
        if (i == 5'd1) e = mk(1'b1, 6'd0, 6'd6, 3'd4);
        if (i == 5'd2) e = mk(1'b1, 6'd55, 6'd12, 3'd5);
      end
      default: begin
        if (i < 5'd5)
          e = mk(i[0], 6'd30 + {1'b0, i},
                 6'd2 + {1'b0, i}, i[2:0]);
      end
    endcase
    return e;
  endfunction

endpackage

// File: rtl/song_note_reader_if.sv
// Note stream handshake: valid/ready plus the presented entry fields.
// master = reader (drives entry), slave = note player (drives ready).
interface song_note_reader_if #(
  parameter int NOTE_W = 6,
  parameter int DUR_W = 6,
  parameter int META_W = 3,
  parameter int IDX_W = 5
);
  logic              note_valid;
  logic              note_ready;
  logic              note_adv;
  logic [NOTE_W-1:0] note_val;
  logic [DUR_W-1:0]  note_dur;
  logic [META_W-1:0] note_meta;
  logic [IDX_W-1:0]  note_index;

  modport master (
    output note_valid, note_adv, note_val,
    output note_dur, note_meta, note_index,
    input  note_ready
  );

  modport slave (
    input  note_valid, note_adv, note_val,
    input  note_dur, note_meta, note_index,
    output note_ready
  );
endinterface

// File: rtl/song_note_reader_rom.sv
// song_rom_mem: synchronous song ROM, 1-cycle read latency.
// Ports: clk, addr (entry address), dout (registered entry).
module song_rom_mem
  import song_pkg::*;
#(
  parameter int    DEPTH = 128,
  parameter int    WIDTH = ENTRY_W,
  parameter string ROM_FILE = "songs.hex"
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] addr,
  output logic [WIDTH-1:0]         dout
);
  // The image is compiled in from song_pkg; an empty
  // ROM_FILE name selects an all-terminator (silent) ROM.
  localparam bit BLANK = (ROM_FILE == "");

  always_ff @(posedge clk) begin
    dout <= BLANK ? '0
                  : WIDTH'(song_image(ROM_AW'(addr)));
  end
endmodule

// File: rtl/song_note_reader.sv
// Multi-song note fetch engine streaming {adv,note,dur,meta} entries.
// Ports: clk, reset_n, play, restart, song_sel, nif (note stream), song_done.
// Build option SONG_LOOP_EN: end-of-song rewinds to index 0 instead of DONE.
module song_note_reader
  import song_pkg::*;
#(
  parameter int    NUM_SONGS = 4,
  parameter int    NOTES_PER_SONG = 32,
  parameter int    NOTE_W = 6,
  parameter int    DUR_W = 6,
  parameter int    META_W = 3,
  parameter string ROM_FILE = "songs.hex",
  parameter int    SONG_W = $clog2(NUM_SONGS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              play,
  input  logic              restart,
  input  logic [SONG_W-1:0] song_sel,
  song_note_reader_if.master nif,
  output logic              song_done
);
  localparam int IDX_W = $clog2(NOTES_PER_SONG);
  localparam int ADDR_W = SONG_W + IDX_W;

  rd_state_t         state_q;
  rd_state_t         state_d;
  logic [SONG_W-1:0] song_q;
  logic [IDX_W-1:0]  idx_q;
  logic [ENTRY_W-1:0] rom_dout;
  note_entry_t       rom_e;

  logic ld_song;
  logic idx_clr;
  logic idx_inc;
  logic present;
  logic drop;
  logic eos;
  logic done_d;
  logic last;
  logic acc;

  song_rom_mem #(
    .DEPTH   (2 ** ADDR_W),
    .WIDTH   (ENTRY_W),
    .ROM_FILE(ROM_FILE)
  ) u_rom (
    .clk (clk),
    .addr({song_q, idx_q}),
    .dout(rom_dout)
  );

  assign rom_e = note_entry_t'(rom_dout);
  assign last = (idx_q == IDX_W'(NOTES_PER_SONG - 1));
  assign acc = nif.note_valid && nif.note_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ld_song = 1'b0;
    idx_clr = 1'b0;
    idx_inc = 1'b0;
    present = 1'b0;
    drop = 1'b0;
    eos = 1'b0;
    done_d = 1'b0;
    if (restart) begin
      // Overrides any same-cycle accept or fetch.
      ld_song = 1'b1;
      idx_clr = 1'b1;
      drop = 1'b1;
      state_d = play ? S_ADDR : S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (play) begin
            ld_song = 1'b1;
            idx_clr = 1'b1;
            state_d = S_ADDR;
          end
        end
        S_ADDR: state_d = S_DATA;
        S_DATA: begin
          if (is_terminator(rom_e)) begin
            eos = 1'b1;
          end else begin
            present = 1'b1;
            state_d = S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (acc) begin
            drop = 1'b1;
            if (last) eos = 1'b1;
            else if (play) begin
              idx_inc = 1'b1;
              state_d = S_ADDR;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_DONE: state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
      if (eos) begin
        done_d = 1'b1;
`ifdef SONG_LOOP_EN
        idx_clr = 1'b1;
        state_d = S_ADDR;
`else
        state_d = S_DONE;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      song_q <= '0;
      idx_q <= '0;
      song_done <= 1'b0;
      nif.note_valid <= 1'b0;
      nif.note_adv <= 1'b0;
      nif.note_val <= '0;
      nif.note_dur <= '0;
      nif.note_meta <= '0;
      nif.note_index <= '0;
    end else begin
      song_done <= done_d;
      if (ld_song) song_q <= song_sel;
      if (idx_clr) idx_q <= '0;
      else if (idx_inc) idx_q <= idx_q + 1'b1;
      if (present) begin
        nif.note_valid <= 1'b1;
        nif.note_adv <= rom_e.adv;
        nif.note_val <= NOTE_W'(rom_e.note);
        nif.note_dur <= DUR_W'(rom_e.dur);
        nif.note_meta <= META_W'(rom_e.meta);
        nif.note_index <= idx_q;
      end else if (drop) begin
        nif.note_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_song_note_reader.sv
// Self-checking bench for song_note_reader: directed scenarios plus
// randomized ready/song streams against a song-table reference model.
module tb_song_note_reader;

  typedef struct packed {
    logic       adv;
    logic [5:0] note;
    logic [5:0] dur;
    logic [2:0] meta;
  } ent_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       play = 1'b0;
  logic       restart = 1'b0;
  logic [1:0] song_sel = 2'd0;
  logic       song_done;

  int checks = 0;
  int errors = 0;

  ent_t song_tbl [4][32];

  song_note_reader_if #(
    .NOTE_W(6), .DUR_W(6), .META_W(3), .IDX_W(5)
  ) nif ();

  song_note_reader dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .play     (play),
    .restart  (restart),
    .song_sel (song_sel),
    .nif      (nif.master),
    .song_done(song_done)
  );

  always #5 clk = ~clk;

  function automatic ent_t cur();
    return {nif.note_adv, nif.note_val,
            nif.note_dur, nif.note_meta};
  endfunction

  function automatic void build_songs();
    for (int s = 0; s < 4; s++)
      for (int i = 0; i < 32; i++) song_tbl[s][i] = '0;
    for (int i = 0; i < 32; i++)
      song_tbl[0][i] = {1'(i % 2), 6'(i + 1),
                        6'(i + 1), 3'(i % 8)};
    song_tbl[1][0] = {1'b1, 6'd44, 6'd8, 3'd1};
    song_tbl[1][1] = {1'b1, 6'd47, 6'd8, 3'd2};
    song_tbl[2][0] = {1'b0, 6'd50, 6'd4, 3'd3};
    song_tbl[2][1] = {1'b1, 6'd0, 6'd6, 3'd4};
    song_tbl[2][2] = {1'b1, 6'd55, 6'd12, 3'd5};
    for (int i = 0; i < 5; i++)
      song_tbl[3][i] = {1'(i % 2), 6'(30 + i),
                        6'(2 + i), 3'(i)};
  endfunction

  // Number of playable entries before the terminator (or 32).
  function automatic int exp_len(int s);
    for (int i = 0; i < 32; i++)
      if (song_tbl[s][i].dur == 6'd0) return i;
    return 32;
  endfunction

  task automatic go_idle();
    @(negedge clk);
    play = 1'b0;
    restart = 1'b1;
    nif.note_ready = 1'b0;
    @(negedge clk);
    restart = 1'b0;
    checks++;
    if (nif.note_valid !== 1'b0) begin
      errors++;
      $display("FAIL go_idle valid got %b want 0",
               nif.note_valid);
    end
  endtask

  // Plays song s to its end with ready asserted pct% of the time,
  // withholding ready for `hold` cycles on each new entry.
  task automatic stream_check(input int s, input int pct,
                              input int hold);
    int   c, n, last_acc, exp_at, loops, target;
    int   exp_n, hold_left;
    bit   term, pend, showing;
    ent_t prev;
    logic [4:0] prev_idx;
    exp_n = exp_len(s);
    term = (exp_n < 32);
`ifdef SONG_LOOP_EN
    target = 2;
`else
    target = 1;
`endif
    @(negedge clk);
    song_sel = 2'(s);
    play = 1'b1;
    nif.note_ready = 1'b0;
    c = 0; n = 0; last_acc = 0; exp_at = 3; loops = 0;
    pend = 0; showing = 0; hold_left = hold;
    prev = '0; prev_idx = '0;
    while (loops < target) begin
      @(posedge clk);
      c++;
      @(negedge clk);
      song_sel = 2'($urandom);
      if (c > 600) begin
        checks++; errors++;
        $display("FAIL timeout song %0d got %0d entries want %0d",
                 s, n, exp_n);
        break;
      end
      if (pend) begin
        checks++;
        if (nif.note_valid !== 1'b0) begin
          errors++;
          $display("FAIL valid_drop song %0d got %b want 0",
                   s, nif.note_valid);
        end
        pend = 0;
      end
      if (song_done === 1'b1) begin
        checks++;
        if (n != exp_n || c != last_acc + (term ? 2 : 0)) begin
          errors++;
          $display("FAIL done song %0d got n=%0d c=%0d want n=%0d c=%0d",
                   s, n, c, exp_n, last_acc + (term ? 2 : 0));
        end
        loops++;
        n = 0;
        exp_at = c + 2;
      end
      if (nif.note_valid === 1'b1) begin
        if (!showing) begin
          checks++;
          if (c != exp_at || n >= exp_n) begin
            errors++;
            $display("FAIL latency song %0d n %0d got c=%0d want c=%0d",
                     s, n, c, exp_at);
          end
          checks++;
          if (cur() !== song_tbl[s][n % 32] ||
              nif.note_index !== 5'(n)) begin
            errors++;
            $display("FAIL entry song %0d got %h/%0d want %h/%0d",
                     s, cur(), nif.note_index,
                     song_tbl[s][n % 32], n);
          end
          prev = cur();
          prev_idx = nif.note_index;
          hold_left = hold;
        end else begin
          checks++;
          if (cur() !== prev || nif.note_index !== prev_idx) begin
            errors++;
            $display("FAIL stable song %0d got %h want %h",
                     s, cur(), prev);
          end
        end
        showing = 1;
        if (hold_left > 0) begin
          nif.note_ready = 1'b0;
          hold_left--;
        end else begin
          nif.note_ready = ($urandom_range(99) < pct);
        end
        if (nif.note_ready) begin
          pend = 1;
          last_acc = c + 1;
          n++;
          exp_at = c + 3;
          showing = 0;
        end
      end else begin
        if (showing) begin
          checks++; errors++;
          $display("FAIL withdrawn song %0d got valid 0 want 1", s);
          showing = 0;
        end
        nif.note_ready = 1'($urandom_range(1));
      end
    end
`ifndef SONG_LOOP_EN
    nif.note_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (nif.note_valid !== 1'b0 || song_done !== 1'b0) begin
        errors++;
        $display("FAIL done_hold got valid %b done %b want 0 0",
                 nif.note_valid, song_done);
      end
    end
`endif
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    nif.note_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (nif.note_valid !== 1'b0 || song_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl got valid %b done %b want 0 0",
               nif.note_valid, song_done);
    end
    checks++;
    if (cur() !== '0 || nif.note_index !== 5'd0) begin
      errors++;
      $display("FAIL reset_fields got %h/%0d want 0/0",
               cur(), nif.note_index);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_song1();
    go_idle();
    stream_check(1, 100, 0);
  endtask

  task automatic test_backpressure();
    go_idle();
    stream_check(2, 100, 10);
  endtask

  task automatic test_full_song();
    go_idle();
    stream_check(0, 100, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      go_idle();
      stream_check(int'($urandom_range(3)),
                   int'($urandom_range(100, 30)), 0);
    end
  endtask

  task automatic test_restart();
    int w;
    go_idle();
    @(negedge clk);
    song_sel = 2'd1;
    play = 1'b1;
    nif.note_ready = 1'b0;
    w = 0;
    while (nif.note_valid !== 1'b1 && w < 10) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (nif.note_valid !== 1'b1) begin
      errors++;
      $display("FAIL restart_setup got valid %b want 1",
               nif.note_valid);
      return;
    end
    nif.note_ready = 1'b1;
    restart = 1'b1;
    song_sel = 2'd2;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      restart = 1'b0;
      nif.note_ready = 1'b0;
      song_sel = 2'd3;
      checks++;
      if (nif.note_valid !== (k == 3) || song_done !== 1'b0) begin
        errors++;
        $display("FAIL restart_valid k %0d got %b/%b want %b/0",
                 k, nif.note_valid, song_done, k == 3);
      end
    end
    checks++;
    if (cur() !== song_tbl[2][0] || nif.note_index !== 5'd0) begin
      errors++;
      $display("FAIL restart_entry got %h/%0d want %h/0",
               cur(), nif.note_index, song_tbl[2][0]);
    end
  endtask

  task automatic test_reset_mid();
    go_idle();
    @(negedge clk);
    song_sel = 2'd3;
    play = 1'b1;
    nif.note_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (nif.note_valid !== 1'b0 || song_done !== 1'b0 ||
        cur() !== '0 || nif.note_index !== 5'd0) begin
      errors++;
      $display("FAIL reset_mid got v%b d%b %h/%0d want all 0",
               nif.note_valid, song_done, cur(), nif.note_index);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (nif.note_valid !== (k == 3)) begin
        errors++;
        $display("FAIL refetch_lat k %0d got %b want %b",
                 k, nif.note_valid, k == 3);
      end
    end
    checks++;
    if (cur() !== song_tbl[3][0] || nif.note_index !== 5'd0) begin
      errors++;
      $display("FAIL refetch_entry got %h/%0d want %h/0",
               cur(), nif.note_index, song_tbl[3][0]);
    end
  endtask

  task automatic test_pause();
    go_idle();
    @(negedge clk);
    song_sel = 2'd2;
    play = 1'b1;
    nif.note_ready = 1'b0;
    @(negedge clk);
    play = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (nif.note_valid !== 1'b1 || cur() !== song_tbl[2][0]) begin
        errors++;
        $display("FAIL pause_present k %0d got %b %h want 1 %h",
                 k, nif.note_valid, cur(), song_tbl[2][0]);
      end
      if (k < 3) @(negedge clk);
    end
    nif.note_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      nif.note_ready = 1'b0;
      checks++;
      if (nif.note_valid !== 1'b0 || song_done !== 1'b0) begin
        errors++;
        $display("FAIL pause_idle got valid %b done %b want 0 0",
                 nif.note_valid, song_done);
      end
    end
  endtask

  initial begin
    nif.note_ready = 1'b0;
    build_songs();
    test_reset();
    test_song1();
    test_backpressure();
    test_full_song();
    test_random();
    test_restart();
    test_reset_mid();
    test_pause();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
